cla_addsub_pipe: RTL and testbench

- Parametrised, carry-pipelined carry-lookahead adder/subtractor for the processor datapath and the Tetris game-logic coprocessor.
- Splits the operands into BLOCK-bit lookahead blocks and resolves one block per pipeline stage, with the block carry registered between stages.
- Throughput: one operation per cycle. Fixed latency.
- Supports add, subtract, add-with-carry and subtract-with-borrow, and produces carry, signed-overflow and zero flags.
- Flow control: valid/ready handshake on both sides.

---
 rtl/cla_addsub_pipe.sv | 132 +++++++++++++
 tb/tb_cla_addsub_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: carry-pipelined lookahead adder/subtractor, one BLOCK-bit block resolved per stage
module cla_addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int N = WIDTH / BLOCK;

    // Two-level sum-of-products carries for one block: c[j] = g[j-1] | p[j-1]g[j-2] | ... | p[j-1..0]c0
    function automatic logic [BLOCK:0] lookahead(input logic [BLOCK-1:0] g, input logic [BLOCK-1:0] p,
                                                 input logic c0);
        logic [BLOCK:0] c;
        logic           t;
        c    = '0;
        c[0] = c0;
        for (int j = 1; j <= BLOCK; j++) begin
            t = c0;
            for (int m = 0; m < j; m++) t = t & p[m];
            c[j] = t;
            for (int k = 0; k < j; k++) begin
                t = g[k];
                for (int m = k + 1; m < j; m++) t = t & p[m];
                c[j] = c[j] | t;
            end
        end
        return c;
    endfunction

    // Stage registers: each holds its beat's whole state (operands, partial sum, block carry)
    logic             vld_q [N];
    logic [WIDTH-1:0] a_q   [N];
    logic [WIDTH-1:0] b_q   [N];
    logic [WIDTH-1:0] s_q   [N];
    logic             c_q   [N];
    logic             ovf_q;
    logic             zero_q;

    // Stage inputs and next-state values
    logic [WIDTH-1:0] xa [N];
    logic [WIDTH-1:0] xb [N];
    logic [WIDTH-1:0] xs [N];
    logic             xc [N];
    logic             xv [N];
    logic [WIDTH-1:0] sn [N];
    logic             cn [N];
    logic [BLOCK-1:0] ab;
    logic [BLOCK-1:0] bb;
    logic [BLOCK:0]   cv;
    logic             ovf_d;
    logic             zero_d;
    logic             en;

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_q[N-1];
    assign sum       = s_q[N-1];
    assign cout      = c_q[N-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // Stage 0 is fed from the ports (with B inverted for subtract); later stages from the previous register
    always_comb begin
        xa[0] = a;
        xb[0] = op[0] ? ~b : b;
        xc[0] = op[1] ? cin : op[0];
        xs[0] = '0;
        xv[0] = in_valid;
        for (int i = 1; i < N; i++) begin
            xa[i] = a_q[i-1];
            xb[i] = b_q[i-1];
            xs[i] = s_q[i-1];
            xc[i] = c_q[i-1];
            xv[i] = vld_q[i-1];
        end
    end

    // Each stage resolves its own block from the incoming block carry; flags come from the last stage
    always_comb begin
        ab = '0;
        bb = '0;
        cv = '0;
        for (int i = 0; i < N; i++) begin
            ab = xa[i][i*BLOCK +: BLOCK];
            bb = xb[i][i*BLOCK +: BLOCK];
            cv = lookahead(ab & bb, ab | bb, xc[i]);
            sn[i] = xs[i];
            sn[i][i*BLOCK +: BLOCK] = ab ^ bb ^ cv[BLOCK-1:0];
            cn[i] = cv[BLOCK];
        end
        ovf_d  = (xa[N-1][WIDTH-1] == xb[N-1][WIDTH-1]) && (sn[N-1][WIDTH-1] != xa[N-1][WIDTH-1]);
        zero_d = sn[N-1] == '0;
    end

    // Whole pipe advances together; a stalled output freezes every stage
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                vld_q[i] <= 1'b0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                s_q[i]   <= '0;
                c_q[i]   <= 1'b0;
            end
        end else if (en) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            for (int i = 0; i < N; i++) begin
                vld_q[i] <= xv[i];
                a_q[i]   <= xa[i];
                b_q[i]   <= xb[i];
                s_q[i]   <= sn[i];
                c_q[i]   <= cn[i];
            end
        end
    end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb_cla_addsub_pipe: directed checks of the pipelined adder/subtractor in three configurations
module tb_cla_addsub_pipe;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  op = '0;
    logic        cin = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    logic        v16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic [1:0]  op16 = '0;
    logic        rdy16;
    logic        ov16;
    logic [15:0] s16;
    logic        c16;
    logic        f16;
    logic        z16;

    logic        v8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [1:0]  op8 = '0;
    logic        rdy8;
    logic        ov8;
    logic [7:0]  s8;
    logic        c8;
    logic        f8;
    logic        z8;

    logic        one = 1'b1;
    logic        nil = 1'b0;

    int checks = 0;
    int failures = 0;
    int delivered = 0;
    logic [34:0] exp_q [$];

    cla_addsub_pipe dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    cla_addsub_pipe #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clock(clock), .reset_n(reset_n), .in_valid(v16), .in_ready(rdy16),
        .a(a16), .b(b16), .op(op16), .cin(nil), .out_valid(ov16), .out_ready(one),
        .sum(s16), .cout(c16), .ovf(f16), .zero(z16)
    );

    cla_addsub_pipe #(.WIDTH(8), .BLOCK(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .in_valid(v8), .in_ready(rdy8),
        .a(a8), .b(b8), .op(op8), .cin(nil), .out_valid(ov8), .out_ready(one),
        .sum(s8), .cout(c8), .ovf(f8), .zero(z8)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: {cout, ovf, zero, sum}
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic [1:0] o, input logic ci);
        logic [31:0] yb;
        logic [32:0] r;
        yb = o[0] ? ~y : y;
        r  = {1'b0, x} + {1'b0, yb} + {32'b0, (o[1] ? ci : o[0])};
        return {r[32], (x[31] == yb[31]) && (r[31] != x[31]), r[31:0] == 32'b0, r[31:0]};
    endfunction

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [1:0] o,
                        input logic ci, input logic [34:0] e);
        a = x;
        b = y;
        op = o;
        cin = ci;
        in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    // Every delivered beat is compared in order against the expected queue
    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            delivered++;
            if (exp_q.size() == 0) check("extra_beat", 64'(1), 64'(0));
            else check("result", 64'({cout, ovf, zero, sum}), 64'(exp_q.pop_front()));
        end
    end

    logic [31:0] ra [8];
    logic [31:0] rb [8];
    logic [1:0]  ro [8];
    logic        rc [8];

    initial begin
        int  j;
        logic stall;
        for (int i = 0; i < 8; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
            ro[i] = 2'($urandom_range(3));
            rc[i] = 1'($urandom_range(1));
        end

        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_flags", 64'({cout, ovf, zero}), 64'(0));
        check("rst_ready", 64'(in_ready), 64'(1));
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        send(32'h7FFFFFFF, 32'h00000001, 2'b00, 1'b0, {1'b0, 1'b1, 1'b0, 32'h80000000});
        in_valid = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clock);
            #1;
            check("latency", 64'(out_valid), 64'(e == 3));
        end
        @(posedge clock);
        #1;

        send(32'd5, 32'd5, 2'b01, 1'b0, {1'b1, 1'b0, 1'b1, 32'h00000000});
        send(32'd0, 32'd1, 2'b01, 1'b0, {1'b0, 1'b0, 1'b0, 32'hFFFFFFFF});
        in_valid = 1'b0;
        for (int e = 2; e <= 5; e++) begin
            @(posedge clock);
            #1;
            check("b2b_valid", 64'(out_valid), 64'(e == 3 || e == 4));
        end

        send(32'hFFFFFFFF, 32'h00000000, 2'b10, 1'b1, {1'b1, 1'b0, 1'b1, 32'h00000000});
        send(32'h00000010, 32'h00000010, 2'b11, 1'b0, {1'b0, 1'b0, 1'b0, 32'hFFFFFFFF});
        in_valid = 1'b0;
        repeat (6) @(posedge clock);
        #1;

        j = 0;
        for (int cy = 0; cy < 12; cy++) begin
            stall = (cy >= 4 && cy < 7);
            out_ready = !stall;
            in_valid = (j < 8);
            if (j < 8) begin
                a = ra[j];
                b = rb[j];
                op = ro[j];
                cin = rc[j];
            end
            #1;
            check("in_ready", 64'(in_ready), 64'(!stall));
            if (stall) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", 64'({cout, ovf, zero, sum}), 64'(exp_q[0]));
            end
            if (j < 8 && !stall) begin
                exp_q.push_back(model(ra[j], rb[j], ro[j], rc[j]));
                j++;
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clock);
        #1;
        check("drained", 64'(exp_q.size()), 64'(0));
        check("delivered", 64'(delivered), 64'(13));

        out_ready = 1'b0;
        send(32'h7FFFFFFF, 32'h00000001, 2'b00, 1'b0, {1'b0, 1'b1, 1'b0, 32'h80000000});
        send(32'h00000003, 32'h00000004, 2'b00, 1'b0, {1'b0, 1'b0, 1'b0, 32'h00000007});
        send(32'h00000009, 32'h00000002, 2'b01, 1'b0, {1'b1, 1'b0, 1'b0, 32'h00000007});
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        check("pre_rst_ovf", 64'(ovf), 64'(1));
        #3;
        reset_n = 1'b0;
        #1;
        check("async_valid", 64'(out_valid), 64'(0));
        check("async_sum", 64'(sum), 64'(0));
        check("async_flags", 64'({cout, ovf, zero}), 64'(0));
        check("async_ready", 64'(in_ready), 64'(1));
        exp_q.delete();
        #8;
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clock);
            #1;
            check("post_rst_idle", 64'(out_valid), 64'(0));
        end

        a16 = 16'h8000;
        b16 = 16'h0001;
        op16 = 2'b01;
        v16 = 1'b1;
        @(posedge clock);
        #1;
        v16 = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clock);
            #1;
            check("w16_latency", 64'(ov16), 64'(e == 3));
        end
        check("w16_sum", 64'(s16), 64'(16'h7FFF));
        check("w16_flags", 64'({c16, f16, z16}), 64'(3'b110));

        a8 = 8'hFF;
        b8 = 8'h01;
        op8 = 2'b00;
        v8 = 1'b1;
        @(posedge clock);
        #1;
        v8 = 1'b0;
        check("w8_valid", 64'(ov8), 64'(1));
        check("w8_sum", 64'(s8), 64'(0));
        check("w8_flags", 64'({c8, f8, z8}), 64'(3'b101));
        @(posedge clock);
        #1;
        check("w8_single", 64'(ov8), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
